stage_if: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the ID stage. It holds the PC and fetches one 32-bit word per instruction through a request/ready handshake with the memory controller. It statically predicts the next PC for JAL and conditional branches, then presents `pc_o`, `inst_o`, `npc_o` and `predict_result_o` to the IF/ID register. It honours stalls from ID or hazard control and redirects from EX on mispredict or JALR.

---
 rtl/stage_if_pkg.sv | 21 ++
 rtl/stage_if_predecode.sv | 45 ++++
 rtl/stage_if.sv | 108 ++++++++++
 tb/tb_stage_if.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package stage_if_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;

  typedef enum logic [1:0] {
    IfIdle,
    IfWait,
    IfDiscard,
    IfValid
  } if_state_t;

endpackage

// File: rtl/stage_if_predecode.sv
// Static next-PC predictor: JAL always taken, backward branches optionally taken.
module if_predecode
  import stage_if_pkg::*;
#(
  parameter bit PREDICT_BACKWARD = 1'b1
) (
  input  logic [InstAddrBus-1:0] pc,
  input  logic [InstBus-1:0]     inst,
  output logic [InstAddrBus-1:0] npc,
  output logic                   predict
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

  // JALR targets depend on a register value, so they fall through as pc+4.
  always_comb begin
    npc     = pc + 32'd4;
    predict = False;
    case (inst[6:0])
      OpcodeJal: begin
        npc     = pc + imm_j;
        predict = True;
      end
      OpcodeBranch: begin
        if (PREDICT_BACKWARD && inst[31]) begin
          npc     = pc + imm_b;
          predict = True;
        end
      end
      OpcodeJalr: begin
        npc     = pc + 32'd4;
        predict = False;
      end
      default: begin
        npc     = pc + 32'd4;
        predict = False;
      end
    endcase
  end

endmodule

// File: rtl/stage_if.sv
// IF stage: holds the PC, fetches one word per instruction over a req/ready
// handshake, predecodes it and presents it to the IF/ID register.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter bit          PREDICT_BACKWARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] npc_o,
  output logic        predict_result_o
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pred_npc;
  logic        pred_taken;

  if_predecode #(
    .PREDICT_BACKWARD(PREDICT_BACKWARD)
  ) u_predecode (
    .pc     (pc),
    .inst   (mem_data_i),
    .npc    (pred_npc),
    .predict(pred_taken)
  );

  // A started memory transaction always runs to completion; a redirect that
  // arrives mid-flight parks in IfDiscard until the stale word comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IfIdle;
      pc               <= RESET_PC;
      mem_req_o        <= False;
      mem_addr_o       <= '0;
      valid_o          <= False;
      pc_o             <= '0;
      inst_o           <= '0;
      npc_o            <= '0;
      predict_result_o <= False;
    end else begin
      case (state)
        IfIdle: begin
          if (redirect_i) begin
            pc <= redirect_pc_i;
          end else begin
            mem_req_o  <= True;
            mem_addr_o <= pc;
            state      <= IfWait;
          end
        end
        IfWait: begin
          if (mem_ready_i && redirect_i) begin
            mem_req_o <= False;
            pc        <= redirect_pc_i;
            state     <= IfIdle;
          end else if (mem_ready_i) begin
            mem_req_o        <= False;
            pc_o             <= pc;
            inst_o           <= mem_data_i;
            npc_o            <= pred_npc;
            predict_result_o <= pred_taken;
            valid_o          <= True;
            state            <= IfValid;
          end else if (redirect_i) begin
            pc    <= redirect_pc_i;
            state <= IfDiscard;
          end
        end
        IfDiscard: begin
          if (redirect_i) begin
            pc <= redirect_pc_i;
          end
          if (mem_ready_i) begin
            mem_req_o <= False;
            state     <= IfIdle;
          end
        end
        IfValid: begin
          if (redirect_i) begin
            valid_o <= False;
            pc      <= redirect_pc_i;
            state   <= IfIdle;
          end else if (!stall_i) begin
            valid_o    <= False;
            pc         <= npc_o;
            mem_req_o  <= True;
            mem_addr_o <= npc_o;
            state      <= IfWait;
          end
        end
        default: state <= IfIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: table of predecode vectors plus
// hand-written stall, redirect and reset sequences, scored through a queue.
module tb_stage_if;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        pred;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] npc_o;
  logic        predict_result_o;

  int     checks = 0;
  int     errors = 0;
  fetch_t sb[$];

  stage_if dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_data_i      (mem_data_i),
    .valid_o         (valid_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .npc_o           (npc_o),
    .predict_result_o(predict_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic waitReq();
    int n = 0;
    while (mem_req_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkValue("req_seen", {31'b0, mem_req_o}, 32'd1);
  endtask

  task automatic doFetch(input fetch_t f, input int latency);
    waitReq();
    checkValue("req_addr", mem_addr_o, f.pc);
    for (int i = 1; i < latency; i++) begin
      @(negedge clk);
      checkValue("req_hold_addr", mem_addr_o, f.pc);
    end
    mem_ready_i = 1'b1;
    mem_data_i  = f.inst;
    sb.push_back(f);
    @(negedge clk);
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
  endtask

  task automatic checkOutput();
    int     n = 0;
    fetch_t e;
    while (valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (valid_o !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: got valid_o=%b, expected 1", valid_o);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_valid: got pc_o=%h, expected no instruction", pc_o);
    end else begin
      e = sb.pop_front();
      checkValue("pc_o", pc_o, e.pc);
      checkValue("inst_o", inst_o, e.inst);
      checkValue("npc_o", npc_o, e.npc);
      checkValue("predict", {31'b0, predict_result_o}, {31'b0, e.pred});
    end
  endtask

  // Redirect for one cycle from a state where it takes effect immediately.
  task automatic applyStimulus(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    @(negedge clk);
    redirect_i    = 1'b0;
    checkValue("redir_valid", {31'b0, valid_o}, 32'd0);
  endtask

  fetch_t vecs[6];
  fetch_t last;
  fetch_t nxt;

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_ready_i = 1'b0; mem_data_i = '0;

    vecs[0] = '{pc: 32'h10, inst: 32'h0100006F, npc: 32'h20, pred: 1'b1};
    vecs[1] = '{pc: 32'h40, inst: 32'hFE000CE3, npc: 32'h38, pred: 1'b1};
    vecs[2] = '{pc: 32'h40, inst: 32'h00000463, npc: 32'h44, pred: 1'b0};
    vecs[3] = '{pc: 32'h80, inst: 32'h00008067, npc: 32'h84, pred: 1'b0};
    vecs[4] = '{pc: 32'h100, inst: 32'hFF1FF06F, npc: 32'hF0, pred: 1'b1};
    vecs[5] = '{pc: 32'h4, inst: 32'hFE000CE3, npc: 32'hFFFFFFFC, pred: 1'b1};

    @(negedge clk);
    @(negedge clk);
    checkValue("rst_req", {31'b0, mem_req_o}, 32'd0);
    checkValue("rst_addr", mem_addr_o, 32'd0);
    checkValue("rst_valid", {31'b0, valid_o}, 32'd0);
    checkValue("rst_pc_o", pc_o, 32'd0);
    checkValue("rst_inst_o", inst_o, 32'd0);
    checkValue("rst_npc_o", npc_o, 32'd0);
    checkValue("rst_pred", {31'b0, predict_result_o}, 32'd0);
    rst = 1'b0;

    doFetch('{pc: 32'h0, inst: 32'h13, npc: 32'h4, pred: 1'b0}, 1);
    checkOutput();
    doFetch('{pc: 32'h4, inst: 32'h13, npc: 32'h8, pred: 1'b0}, 2);
    checkOutput();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].pc);
      doFetch(vecs[k], 1 + (k % 3));
      checkOutput();
      last = '{pc: vecs[k].npc, inst: 32'h13, npc: vecs[k].npc + 32'd4, pred: 1'b0};
      doFetch(last, 1);
      checkOutput();
    end

    // Hold in VALID for three cycles, then release.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkValue("stall_valid", {31'b0, valid_o}, 32'd1);
      checkValue("stall_pc_o", pc_o, last.pc);
      checkValue("stall_inst_o", inst_o, last.inst);
      checkValue("stall_npc_o", npc_o, last.npc);
      checkValue("stall_req", {31'b0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    @(negedge clk);
    checkValue("release_req", {31'b0, mem_req_o}, 32'd1);
    checkValue("release_addr", mem_addr_o, last.npc);
    nxt = '{pc: last.npc, inst: 32'h13, npc: last.npc + 32'd4, pred: 1'b0};
    doFetch(nxt, 3);
    checkOutput();

    // Redirect while waiting: old access completes, data is dropped.
    @(negedge clk);
    checkValue("wait_addr", mem_addr_o, nxt.npc);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkValue("discard_req", {31'b0, mem_req_o}, 32'd1);
      checkValue("discard_addr", mem_addr_o, nxt.npc);
      checkValue("discard_valid", {31'b0, valid_o}, 32'd0);
      if (i == 0) @(negedge clk);
    end
    mem_ready_i = 1'b1; mem_data_i = 32'h0100006F;
    @(negedge clk);
    mem_ready_i = 1'b0; mem_data_i = '0;
    checkValue("discard_drop_valid", {31'b0, valid_o}, 32'd0);
    checkValue("discard_drop_req", {31'b0, mem_req_o}, 32'd0);
    doFetch('{pc: 32'h100, inst: 32'h13, npc: 32'h104, pred: 1'b0}, 1);
    checkOutput();

    // Redirect coinciding with mem_ready_i.
    @(negedge clk);
    checkValue("sim_addr", mem_addr_o, 32'h104);
    mem_ready_i = 1'b1; mem_data_i = 32'h13;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk);
    mem_ready_i = 1'b0; mem_data_i = '0; redirect_i = 1'b0;
    checkValue("sim_valid", {31'b0, valid_o}, 32'd0);
    checkValue("sim_req", {31'b0, mem_req_o}, 32'd0);
    doFetch('{pc: 32'h200, inst: 32'h13, npc: 32'h204, pred: 1'b0}, 1);
    checkOutput();

    // Redirect beats stall in VALID.
    stall_i = 1'b1;
    applyStimulus(32'h300);
    doFetch('{pc: 32'h300, inst: 32'h0100006F, npc: 32'h310, pred: 1'b1}, 2);
    checkOutput();
    @(negedge clk);
    checkValue("stall_hold_valid", {31'b0, valid_o}, 32'd1);
    checkValue("stall_hold_req", {31'b0, mem_req_o}, 32'd0);

    // Asynchronous reset in the middle of a transaction.
    stall_i = 1'b0;
    @(negedge clk);
    checkValue("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
    checkValue("pre_rst_addr", mem_addr_o, 32'h310);
    #2 rst = 1'b1;
    #1;
    checkValue("async_rst_req", {31'b0, mem_req_o}, 32'd0);
    checkValue("async_rst_addr", mem_addr_o, 32'd0);
    checkValue("async_rst_valid", {31'b0, valid_o}, 32'd0);

    checkValue("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
